// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, FSM states,
// datapath select codes and the decoded instruction-class record.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALU_W   = 3;

    localparam logic [OP_W-1:0] OP_R   = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI = 6'b001111;
    localparam logic [OP_W-1:0] OP_J   = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR   = 6'b001000;

    localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] S_EXE    = 3'd2;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] S_WB     = 3'd4;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd5;

    localparam logic [SEL_W-1:0] NPC_PC4 = 2'd0;
    localparam logic [SEL_W-1:0] NPC_BR  = 2'd1;
    localparam logic [SEL_W-1:0] NPC_J   = 2'd2;
    localparam logic [SEL_W-1:0] NPC_RS  = 2'd3;

    localparam logic [SEL_W-1:0] RD_RT = 2'd0;
    localparam logic [SEL_W-1:0] RD_RD = 2'd1;
    localparam logic [SEL_W-1:0] RD_RA = 2'd2;

    localparam logic [SEL_W-1:0] WD_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WD_MDR = 2'd1;
    localparam logic [SEL_W-1:0] WD_PC  = 2'd2;

    localparam logic [SEL_W-1:0] EXT_ZERO = 2'd0;
    localparam logic [SEL_W-1:0] EXT_SIGN = 2'd1;
    localparam logic [SEL_W-1:0] EXT_LUI  = 2'd2;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
        logic nop;
    } insn_cls_t;

    // Instructions that complete in DECODE without touching the ALU or memory
    function automatic logic retires_in_decode(input insn_cls_t c);
        return c.j | c.jal | c.jr | c.nop;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller-to-datapath bundle: IR fields and memory status in, strobes and
// selects out, plus the retire counter and timeout flag.
interface mc_if
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic [OP_W-1:0]  opcode;
    logic [OP_W-1:0]  funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_re;
    logic             mem_we;
    logic             iord;
    logic             ir_we;
    logic             pc_we;
    logic [SEL_W-1:0] npc_sel;
    logic             reg_we;
    logic [SEL_W-1:0] reg_dst;
    logic [SEL_W-1:0] wd_sel;
    logic             alu_src_b;
    logic [SEL_W-1:0] ext_op;
    logic [ALU_W-1:0] alu_op;
    logic             retire;
    logic [CNT_W-1:0] retired;
    logic             err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_re, mem_we, iord, ir_we, pc_we, npc_sel, reg_we, reg_dst,
               wd_sel, alu_src_b, ext_op, alu_op, retire, retired, err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_re, mem_we, iord, ir_we, pc_we, npc_sel, reg_we, reg_dst,
               wd_sel, alu_src_b, ext_op, alu_op, retire, retired, err
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational IR decode into one-hot instruction classes; anything not
// recognised falls into the nop class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    output insn_cls_t       cls
);
    logic is_r;

    assign is_r = (opcode == OP_R);

    always_comb begin
        cls      = '0;
        cls.addu = is_r && (funct == FN_ADDU);
        cls.subu = is_r && (funct == FN_SUBU);
        cls.jr   = is_r && (funct == FN_JR);
        cls.ori  = (opcode == OP_ORI);
        cls.lw   = (opcode == OP_LW);
        cls.sw   = (opcode == OP_SW);
        cls.beq  = (opcode == OP_BEQ);
        cls.lui  = (opcode == OP_LUI);
        cls.j    = (opcode == OP_J);
        cls.jal  = (opcode == OP_JAL);
        cls.nop  = !(cls.addu | cls.subu | cls.jr | cls.ori | cls.lw | cls.sw |
                     cls.beq | cls.lui | cls.j | cls.jal);
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXE/MEM/WB/HALT FSM with memory
// wait-state timeout and a retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic   clk,
    input logic   reset,
    mc_if.master  bus
);
    insn_cls_t          cls;
    logic [STATE_W-1:0] state, state_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_nx, wait_inc;
    logic               wait_expired;
    logic [CNT_W-1:0]   retired_q;
    logic               err_q, err_set;

    logic               mem_re, mem_we, iord, ir_we, pc_we, reg_we;
    logic               alu_src_b, retire;
    logic [SEL_W-1:0]   npc_sel, reg_dst, wd_sel, ext_op;
    logic [ALU_W-1:0]   alu_op;

    mc_decode u_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .cls    (cls)
    );

    assign wait_inc     = wait_cnt + WAIT_W'(1);
    assign wait_expired = (wait_inc == WAIT_W'(MEM_TIMEOUT));

    // State, wait counter, retire counter and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next state and per-state strobes; everything is forced low while reset is held
    always_comb begin
        state_nx  = state;
        wait_nx   = '0;
        err_set   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        npc_sel   = NPC_PC4;
        reg_we    = 1'b0;
        reg_dst   = RD_RT;
        wd_sel    = WD_ALU;
        alu_src_b = 1'b0;
        ext_op    = EXT_ZERO;
        alu_op    = ALU_ADD;
        retire    = 1'b0;

        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_re = 1'b1;
                    if (bus.mem_ready) begin
                        ir_we    = 1'b1;
                        pc_we    = 1'b1;
                        npc_sel  = NPC_PC4;
                        state_nx = S_DECODE;
                    end else if (wait_expired) begin
                        err_set  = 1'b1;
                        state_nx = S_HALT;
                    end else begin
                        wait_nx = wait_inc;
                    end
                end

                S_DECODE: begin
                    if (cls.j || cls.jal) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_J;
                    end
                    if (cls.jal) begin
                        reg_we  = 1'b1;
                        reg_dst = RD_RA;
                        wd_sel  = WD_PC;
                    end
                    if (cls.jr) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_RS;
                    end
                    if (retires_in_decode(cls)) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_EXE;
                    end
                end

                S_EXE: begin
                    state_nx = S_WB;
                    if (cls.subu) begin
                        alu_op = ALU_SUB;
                    end else if (cls.ori || cls.lui) begin
                        alu_src_b = 1'b1;
                        ext_op    = cls.lui ? EXT_LUI : EXT_ZERO;
                        alu_op    = ALU_OR;
                    end else if (cls.lw || cls.sw) begin
                        alu_src_b = 1'b1;
                        ext_op    = EXT_SIGN;
                        state_nx  = S_MEM;
                    end else if (cls.beq) begin
                        alu_op   = ALU_SUB;
                        pc_we    = bus.zero;
                        npc_sel  = NPC_BR;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else if (!cls.addu) begin
                        state_nx = S_FETCH;
                    end
                end

                S_MEM: begin
                    iord   = 1'b1;
                    mem_re = cls.lw;
                    mem_we = cls.sw;
                    if (bus.mem_ready) begin
                        if (cls.sw) begin
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end else begin
                            state_nx = S_WB;
                        end
                    end else if (wait_expired) begin
                        err_set  = 1'b1;
                        state_nx = S_HALT;
                    end else begin
                        wait_nx = wait_inc;
                    end
                end

                S_WB: begin
                    reg_we   = 1'b1;
                    reg_dst  = (cls.addu || cls.subu) ? RD_RD : RD_RT;
                    wd_sel   = cls.lw ? WD_MDR : WD_ALU;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end

                S_HALT: begin
                    state_nx = S_HALT;
                end

                default: begin
                    state_nx = S_FETCH;
                end
            endcase
        end
    end

    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.iord      = iord;
    assign bus.ir_we     = ir_we;
    assign bus.pc_we     = pc_we;
    assign bus.npc_sel   = npc_sel;
    assign bus.reg_we    = reg_we;
    assign bus.reg_dst   = reg_dst;
    assign bus.wd_sel    = wd_sel;
    assign bus.alu_src_b = alu_src_b;
    assign bus.ext_op    = ext_op;
    assign bus.alu_op    = alu_op;
    assign bus.retire    = retire;
    assign bus.retired   = retired_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle strobe vectors for each instruction
// class, memory wait states, timeout/HALT and reset abort.
module tb_mc_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   passed;

    mc_if #(.CNT_W(32)) bus ();

    mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // {mem_re, mem_we, iord, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src_b, ext_op, alu_op, retire}
    logic [18:0] strb;
    assign strb = {bus.mem_re, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.npc_sel,
                   bus.reg_we, bus.reg_dst, bus.wd_sel, bus.alu_src_b, bus.ext_op,
                   bus.alu_op, bus.retire};

    function automatic logic [18:0] e(input int re, input int we, input int io, input int irw,
                                      input int pcw, input int npc, input int rw, input int rd,
                                      input int wd, input int asb, input int ext, input int aop,
                                      input int ret);
        return {1'(re), 1'(we), 1'(io), 1'(irw), 1'(pcw), 2'(npc), 1'(rw), 2'(rd),
                2'(wd), 1'(asb), 2'(ext), 3'(aop), 1'(ret)};
    endfunction

    logic [18:0] f_rdy, f_wait, wb_r, wb_i;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000000;
        bus.funct = 6'b100001;
        bus.zero = 1'b0;
        tick();
        checks++;
        if (strb !== 19'd0) $display("FAIL reset_strobes_c1 got %h want %h", strb, 19'd0);
        else passed++;
        tick();
        checks++;
        if (strb !== 19'd0) $display("FAIL reset_strobes_c2 got %h want %h", strb, 19'd0);
        else passed++;
        checks++;
        if (bus.retired !== 32'd0 || bus.err !== 1'b0)
            $display("FAIL reset_regs retired=%0d err=%b want 0/0", bus.retired, bus.err);
        else passed++;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (strb !== f_wait) $display("FAIL reset_release got %h want %h", strb, f_wait);
        else passed++;
        tick();
    endtask

    task automatic test_addu();
        logic [18:0] exp [4];
        exp = '{f_rdy, 19'd0, 19'd0, wb_r};
        bus.opcode = 6'b000000;
        bus.funct = 6'b100001;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (strb !== exp[i]) $display("FAIL addu_c%0d got %h want %h", i, strb, exp[i]);
            else passed++;
            tick();
        end
        checks++;
        if (bus.retired !== 32'd1) $display("FAIL addu_retired got %0d want 1", bus.retired);
        else passed++;
    endtask

    task automatic test_lw_wait();
        logic [18:0] exp [8];
        logic        rdy [8];
        logic [18:0] m_lw;
        m_lw = e(1,0,1,0,0,0,0,0,0,0,0,0,0);
        exp = '{f_rdy, 19'd0, e(0,0,0,0,0,0,0,0,0,1,1,0,0), m_lw, m_lw, m_lw, m_lw,
                e(0,0,0,0,0,0,1,0,1,0,0,0,1)};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 6'b100011;
        bus.funct = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            checks++;
            if (strb !== exp[i]) $display("FAIL lw_c%0d got %h want %h", i, strb, exp[i]);
            else passed++;
            tick();
        end
        checks++;
        if (bus.retired !== 32'd2) $display("FAIL lw_retired got %0d want 2", bus.retired);
        else passed++;
    endtask

    task automatic test_beq();
        logic [18:0] exp [6];
        logic        zr [6];
        exp = '{f_rdy, 19'd0, e(0,0,0,0,1,1,0,0,0,0,0,1,1),
                f_rdy, 19'd0, e(0,0,0,0,0,1,0,0,0,0,0,1,1)};
        zr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.opcode = 6'b000100;
        bus.funct = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = 1'b1;
            bus.zero = zr[i];
            #1;
            checks++;
            if (strb !== exp[i]) $display("FAIL beq_c%0d got %h want %h", i, strb, exp[i]);
            else passed++;
            tick();
        end
        bus.zero = 1'b0;
        checks++;
        if (bus.retired !== 32'd4) $display("FAIL beq_retired got %0d want 4", bus.retired);
        else passed++;
    endtask

    task automatic test_jal();
        logic [18:0] exp [2];
        exp = '{f_rdy, e(0,0,0,0,1,2,1,2,2,0,0,0,1)};
        bus.opcode = 6'b000011;
        bus.funct = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (strb !== exp[i]) $display("FAIL jal_c%0d got %h want %h", i, strb, exp[i]);
            else passed++;
            tick();
        end
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (strb !== f_wait) $display("FAIL jal_next_fetch got %h want %h", strb, f_wait);
        else passed++;
        checks++;
        if (bus.retired !== 32'd5) $display("FAIL jal_retired got %0d want 5", bus.retired);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op [24];
        logic [5:0]  fn [24];
        logic [18:0] exp [24];
        op = '{6'o00, 6'o00, 6'o00, 6'o00, 6'b001101, 6'b001101, 6'b001101, 6'b001101,
               6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b101011, 6'b101011, 6'b101011, 6'b101011,
               6'b000010, 6'b000010, 6'o00, 6'o00, 6'o00, 6'o00, 6'b111111, 6'b111111};
        fn = '{6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'o00, 6'o00, 6'o00, 6'o00,
               6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00,
               6'o00, 6'o00, 6'b001000, 6'b001000, 6'o00, 6'o00, 6'o00, 6'o00};
        exp = '{f_rdy, 19'd0, e(0,0,0,0,0,0,0,0,0,0,0,1,0), wb_r,
                f_rdy, 19'd0, e(0,0,0,0,0,0,0,0,0,1,0,2,0), wb_i,
                f_rdy, 19'd0, e(0,0,0,0,0,0,0,0,0,1,2,2,0), wb_i,
                f_rdy, 19'd0, e(0,0,0,0,0,0,0,0,0,1,1,0,0), e(0,1,1,0,0,0,0,0,0,0,0,0,1),
                f_rdy, e(0,0,0,0,1,2,0,0,0,0,0,0,1),
                f_rdy, e(0,0,0,0,1,3,0,0,0,0,0,0,1),
                f_rdy, e(0,0,0,0,0,0,0,0,0,0,0,0,1),
                f_rdy, e(0,0,0,0,0,0,0,0,0,0,0,0,1)};
        for (int i = 0; i < 24; i++) begin
            bus.opcode = op[i];
            bus.funct = fn[i];
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (strb !== exp[i]) $display("FAIL b2b_c%0d op=%b got %h want %h", i, op[i], strb, exp[i]);
            else passed++;
            tick();
        end
        checks++;
        if (bus.retired !== 32'd13) $display("FAIL b2b_retired got %0d want 13", bus.retired);
        else passed++;
    endtask

    task automatic test_timeout();
        bus.opcode = 6'b000000;
        bus.funct = 6'b100001;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (strb !== f_wait || bus.err !== 1'b0)
                $display("FAIL timeout_wait_c%0d got %h err=%b want %h err=0", i, strb, bus.err, f_wait);
            else passed++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (strb !== 19'd0 || bus.err !== 1'b1)
                $display("FAIL halt_c%0d got %h err=%b want 0 err=1", i, strb, bus.err);
            else passed++;
            tick();
        end
        checks++;
        if (bus.retired !== 32'd13) $display("FAIL halt_retired got %0d want 13", bus.retired);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.err !== 1'b0 || bus.retired !== 32'd0)
            $display("FAIL halt_reset err=%b retired=%0d want 0/0", bus.err, bus.retired);
        else passed++;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (strb !== f_wait) $display("FAIL halt_exit got %h want %h", strb, f_wait);
        else passed++;
        tick();
    endtask

    task automatic test_reset_abort();
        logic [18:0] exp [3];
        exp = '{f_rdy, 19'd0, e(0,0,0,0,0,0,0,0,0,1,1,0,0)};
        bus.opcode = 6'b101011;
        bus.funct = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (strb !== exp[i]) $display("FAIL abort_c%0d got %h want %h", i, strb, exp[i]);
            else passed++;
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (strb !== 19'd0) $display("FAIL abort_mem got %h want %h", strb, 19'd0);
        else passed++;
        tick();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (strb !== f_rdy || bus.retired !== 32'd0)
            $display("FAIL abort_refetch got %h retired=%0d want %h retired=0", strb, bus.retired, f_rdy);
        else passed++;
        tick();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        f_rdy  = e(1,0,0,1,1,0,0,0,0,0,0,0,0);
        f_wait = e(1,0,0,0,0,0,0,0,0,0,0,0,0);
        wb_r   = e(0,0,0,0,0,0,1,1,0,0,0,0,1);
        wb_i   = e(0,0,0,0,0,0,1,0,0,0,0,0,1);
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jal();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
